// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with a shared period counter and shadow/active duty and period registers.
// Define PWM_DEADTIME_EN to add per-channel dead-time insertion on the high/low gate pair.
module pwm_multi_ch #(
  parameter int WIDTH      = 9,
  parameter int CHANNELS   = 2,
  parameter int CH_W       = 1,
  parameter int DEAD       = 4,
  parameter int RST_PERIOD = 511
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                per_ld,
  input  logic [WIDTH-1:0]    per_in,
  input  logic                duty_ld,
  input  logic [CH_W-1:0]     duty_ch,
  input  logic [WIDTH-1:0]    duty_in,
  output logic [WIDTH-1:0]    cnt,
  output logic                wrap,
  output logic [CHANNELS-1:0] out_h,
  output logic [CHANNELS-1:0] out_l
);

  localparam logic [WIDTH-1:0] RST_PER = WIDTH'(RST_PERIOD);

  logic [WIDTH-1:0]    per_sh;
  logic [WIDTH-1:0]    per_act;
  logic [WIDTH-1:0]    duty_sh  [CHANNELS];
  logic [WIDTH-1:0]    duty_act [CHANNELS];
  logic [CHANNELS-1:0] raw;

  assign wrap = (cnt == per_act);

  // Active registers only move at the wrap edge, or continuously while stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      per_sh  <= RST_PER;
      per_act <= RST_PER;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      if (!en || wrap) cnt <= '0;
      else             cnt <= cnt + WIDTH'(1);

      if (per_ld)      per_sh  <= per_in;
      if (!en || wrap) per_act <= per_sh;

      for (int i = 0; i < CHANNELS; i++) begin
        if (duty_ld && (duty_ch == CH_W'(i))) duty_sh[i] <= duty_in;
        if (!en || wrap)                      duty_act[i] <= duty_sh[i];
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < CHANNELS; i++)
      raw[i] = en & (cnt < duty_act[i]);
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [7:0] DEAD_V = 8'(DEAD);

  logic [CHANNELS-1:0] raw_q;
  logic [7:0]          dt_cnt [CHANNELS];

  // Any edge of raw blanks both gates; a new edge inside the window restarts it.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      raw_q <= '0;
      out_h <= '0;
      out_l <= '0;
      for (int i = 0; i < CHANNELS; i++) dt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        raw_q[i] <= raw[i];
        if (raw[i] != raw_q[i]) begin
          if (DEAD_V == 8'd0) begin
            out_h[i] <= raw[i];
            out_l[i] <= ~raw[i];
          end else begin
            out_h[i]  <= 1'b0;
            out_l[i]  <= 1'b0;
            dt_cnt[i] <= DEAD_V - 8'd1;
          end
        end else if (dt_cnt[i] != 8'd0) begin
          out_h[i]  <= 1'b0;
          out_l[i]  <= 1'b0;
          dt_cnt[i] <= dt_cnt[i] - 8'd1;
        end else begin
          out_h[i] <= raw[i];
          out_l[i] <= ~raw[i];
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      out_h <= '0;
      out_l <= '0;
    end else begin
      out_h <= raw;
      out_l <= {CHANNELS{en}} & ~raw;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized and directed bench for pwm_multi_ch against a cycle-level behavioural reference.
module tb_pwm_multi_ch;
  localparam int WIDTH = 9;
  localparam int CH    = 3;
  localparam int CH_W  = 2;
  localparam int RSTP  = 511;
`ifdef PWM_DEADTIME_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int BIG = 100000;

  logic             clk = 1'b0;
  logic             rst = 1'b1, en = 1'b0, per_ld = 1'b0, duty_ld = 1'b0;
  logic [WIDTH-1:0] per_in = '0, duty_in = '0;
  logic [CH_W-1:0]  duty_ch = '0;
  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic [CH-1:0]    out_h, out_l;

  pwm_multi_ch #(.WIDTH(WIDTH), .CHANNELS(CH), .CH_W(CH_W), .DEAD(D == 0 ? 4 : D),
                 .RST_PERIOD(RSTP)) dut (
    .clk(clk), .rst(rst), .en(en), .per_ld(per_ld), .per_in(per_in),
    .duty_ld(duty_ld), .duty_ch(duty_ch), .duty_in(duty_in),
    .cnt(cnt), .wrap(wrap), .out_h(out_h), .out_l(out_l)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // reference state: counter, shadow/active registers, and run length of each raw level
  bit      m_valid = 0;
  int      m_cnt, m_per_act, m_per_sh;
  int      m_duty_sh [CH];
  int      m_duty_act[CH];
  bit      m_lvl[CH];
  int      m_run[CH];
  bit [CH-1:0] m_h, m_l;

  bit meas = 0;
  int hcnt[CH], lcnt[CH], wcnt;

  task automatic model_reset();
    m_cnt = 0; m_per_act = RSTP; m_per_sh = RSTP; m_h = '0; m_l = '0;
    for (int i = 0; i < CH; i++) begin
      m_duty_sh[i] = 0; m_duty_act[i] = 0; m_lvl[i] = 0; m_run[i] = BIG;
    end
  endtask

  task automatic step();
    int  n_cnt;
    bit  xfer, r;
    @(negedge clk);
    if (m_valid) begin
      check("cnt", cnt, m_cnt);
      check("wrap", wrap, (m_cnt == m_per_act));
      check("out_h", out_h, m_h);
      check("out_l", out_l, m_l);
      if (out_h & out_l) check("overlap", out_h & out_l, 0);
    end
    if (meas) begin
      for (int i = 0; i < CH; i++) begin
        hcnt[i] += out_h[i];
        lcnt[i] += out_l[i];
      end
      wcnt += wrap;
    end
    if (rst) begin
      model_reset();
      m_valid = 1;
    end else begin
      xfer = !en || (m_cnt == m_per_act);
      for (int i = 0; i < CH; i++) begin
        r = en && (m_cnt < m_duty_act[i]);
        if (!en) begin
          m_lvl[i] = 0; m_run[i] = BIG;
        end else if (r == m_lvl[i]) begin
          if (m_run[i] < BIG) m_run[i]++;
        end else begin
          m_lvl[i] = r; m_run[i] = 1;
        end
        m_h[i] = en && m_run[i] > D && m_lvl[i];
        m_l[i] = en && m_run[i] > D && !m_lvl[i];
      end
      n_cnt = (!en || m_cnt == m_per_act) ? 0 : m_cnt + 1;
      if (xfer) begin
        m_per_act = m_per_sh;
        for (int i = 0; i < CH; i++) m_duty_act[i] = m_duty_sh[i];
      end
      if (per_ld) m_per_sh = per_in;
      if (duty_ld && duty_ch < CH) m_duty_sh[duty_ch] = duty_in;
      m_cnt = n_cnt;
    end
    @(posedge clk);
    #1;
    per_ld  = 1'b0;
    duty_ld = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_cnt(input int v);
    int k = 0;
    while (m_cnt != v && k < 1000) begin
      step();
      k++;
    end
    if (m_cnt != v) check("wait_cnt_timeout", 0, 1);
  endtask

  task automatic measure(input int n);
    for (int i = 0; i < CH; i++) begin hcnt[i] = 0; lcnt[i] = 0; end
    wcnt = 0;
    meas = 1;
    run(n);
    meas = 0;
  endtask

  function automatic int exp_hi(input int duty, input int per);
    if (duty == 0) return 0;
    if (duty > per) return per + 1;
    return (duty > D) ? duty - D : 0;
  endfunction

  function automatic int exp_lo(input int duty, input int per);
    if (duty == 0) return per + 1;
    if (duty > per) return 0;
    return (per + 1 - duty > D) ? per + 1 - duty - D : 0;
  endfunction

  task automatic load_duty(input int ch, input int v);
    duty_ld = 1'b1; duty_ch = CH_W'(ch); duty_in = WIDTH'(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    run(3);
    rst = 1'b0;

    per_ld = 1'b1; per_in = 9; load_duty(0, 3);
    step();
    load_duty(1, 10); step();
    load_duty(2, 2);  step();
    run(3);
    en = 1'b1;
    run(22);
    measure(10);
    check("p9_h0", hcnt[0], exp_hi(3, 9));
    check("p9_l0", lcnt[0], exp_lo(3, 9));
    check("p9_h1", hcnt[1], exp_hi(10, 9));
    check("p9_h2", hcnt[2], exp_hi(2, 9));
    check("p9_wrap", wcnt, 1);

    wait_cnt(4); load_duty(0, 7); step();
    run(30);
    wait_cnt(9); load_duty(0, 5); step();
    run(30);

    wait_cnt(2); per_ld = 1'b1; per_in = 4; load_duty(0, 3); step();
    run(25);
    measure(5);
    check("p4_h0", hcnt[0], exp_hi(3, 4));
    check("p4_l0", lcnt[0], exp_lo(3, 4));
    check("p4_wrap", wcnt, 1);

    wait_cnt(2); en = 1'b0; step();
    en = 1'b1; run(12);
    wait_cnt(3); rst = 1'b1; step();
    rst = 1'b0; run(20);
    measure(20);
    check("rst_h0", hcnt[0], 0);
    check("rst_l0", lcnt[0], 20);
    check("rst_wrap", wcnt, 0);

    per_ld = 1'b1; per_in = 6; step();
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 29) == 0) begin
        per_ld = 1'b1; per_in = WIDTH'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 7) == 0) begin
        duty_ld = 1'b1;
        duty_ch = CH_W'($urandom_range(0, 3));
        duty_in = WIDTH'($urandom_range(0, 18));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
